// File: rtl/ntsc_frame_writer_pkg.sv
// Shared constants and types for the NTSC frame writer.
// Frame geometry, the frame-buffer address layout, the pixel field widths and
// the layout of one queued write entry.
package ntsc_frame_writer_pkg;

    localparam int WORDS_PER_LINE  = 320;
    localparam int LINES_PER_FRAME = 480;
    localparam int FRAME_WORDS     = 153600;

    localparam int ADDR_W   = 19;
    localparam int OFFSET_W = 18;
    localparam int DATA_W   = 36;
    localparam int ENTRY_W  = ADDR_W + DATA_W;

    localparam int Y_W     = 8;
    localparam int CR_W    = 5;
    localparam int CB_W    = 5;
    localparam int PIXEL_W = Y_W + CR_W + CB_W;

    typedef struct packed {
        logic                bank;
        logic [OFFSET_W-1:0] offset;
        logic [DATA_W-1:0]   data;
    } wr_entry_t;

    // Build one queued write entry from its parts.
    function automatic wr_entry_t pack_entry(input logic                bank,
                                             input logic [OFFSET_W-1:0] offset,
                                             input logic [DATA_W-1:0]   data);
        wr_entry_t e;
        e.bank   = bank;
        e.offset = offset;
        e.data   = data;
        return e;
    endfunction

endpackage

// File: rtl/ntsc_frame_writer_wr_fifo.sv
// Synchronous write-entry FIFO. DEPTH must be a power of two.
// A push while full and a pop while empty are ignored.
module wr_fifo
    import ntsc_frame_writer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == CNT_W'(0));
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign head      = mem_r[rd_ptr_r];

    // Entry storage; contents are only meaningful while counted, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Read/write pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ntsc_frame_writer.sv
// NTSC frame writer: turns captured two-pixel words into queued frame-buffer
// writes for the ZBT arbiter and double-buffers whole frames.
// Optional macro NTSC_WRITER_DROP_CNT_EN adds a saturating drop_count output.
module ntsc_frame_writer
    import ntsc_frame_writer_pkg::*;
#(
    parameter int FIFO_DEPTH      = 8,
    parameter int WORDS_PER_LINE  = ntsc_frame_writer_pkg::WORDS_PER_LINE,
    parameter int LINES_PER_FRAME = ntsc_frame_writer_pkg::LINES_PER_FRAME
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic [DATA_W-1:0] ntsc_pixels,
    input  logic              ntsc_flag,
    input  logic              frame_flag,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic              mem_ack,
    output logic              display_bank,
    output logic              frame_done,
    output logic              overflow
`ifdef NTSC_WRITER_DROP_CNT_EN
    ,
    output logic [15:0]       drop_count
`endif
);

    localparam int XW = $clog2(WORDS_PER_LINE);
    localparam logic [OFFSET_W-1:0] LAST_BASE =
        OFFSET_W'((LINES_PER_FRAME - 1) * WORDS_PER_LINE);

    logic [XW-1:0]       x_word_r, x_word_n;
    logic [OFFSET_W-1:0] line_base_r, line_base_n;
    logic                write_bank_r, write_bank_n;
    logic                pending_swap_r, pending_swap_n;
    logic                display_bank_r;
    logic                frame_done_r;
    logic                overflow_r;

    logic [OFFSET_W-1:0] offset_s;
    logic                full_s;
    logic                empty_s;
    logic                push_s;
    logic                drop_s;
    logic                pop_s;
    logic                swap_ready_s;
    wr_entry_t           entry_s;
    wr_entry_t           head_s;

    assign offset_s = line_base_r + OFFSET_W'(x_word_r);
    assign entry_s  = pack_entry(write_bank_r, offset_s, ntsc_pixels);
    // Full is judged before any same-cycle pop, so a full FIFO always drops.
    assign push_s   = ntsc_flag & ~full_s;
    assign drop_s   = ntsc_flag & full_s;
    assign pop_s    = mem_ack & ~empty_s;
    // The old frame is finished once no entry ahead carries the previous bank.
    assign swap_ready_s = pending_swap_r & ~frame_flag &
                          (empty_s | (head_s.bank == write_bank_r));

    wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset_b),
        .push  (push_s),
        .pop   (pop_s),
        .din   (entry_s),
        .full  (full_s),
        .empty (empty_s),
        .head  (head_s)
    );

    // Next position/bank: frame_flag restarts the frame after this cycle's word.
    always_comb begin
        x_word_n       = x_word_r;
        line_base_n    = line_base_r;
        write_bank_n   = write_bank_r;
        pending_swap_n = pending_swap_r;
        if (frame_flag) begin
            x_word_n       = XW'(0);
            line_base_n    = OFFSET_W'(0);
            write_bank_n   = ~write_bank_r;
            pending_swap_n = 1'b1;
        end else begin
            if (ntsc_flag) begin
                if (x_word_r == XW'(WORDS_PER_LINE - 1)) begin
                    x_word_n = XW'(0);
                    if (line_base_r == LAST_BASE) begin
                        line_base_n = OFFSET_W'(0);
                    end else begin
                        line_base_n = line_base_r + OFFSET_W'(WORDS_PER_LINE);
                    end
                end else begin
                    x_word_n = x_word_r + XW'(1);
                end
            end else begin
                x_word_n = x_word_r;
            end
            if (swap_ready_s) begin
                pending_swap_n = 1'b0;
            end else begin
                pending_swap_n = pending_swap_r;
            end
        end
    end

    // Position, bank and swap-status registers.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            x_word_r       <= XW'(0);
            line_base_r    <= OFFSET_W'(0);
            write_bank_r   <= 1'b0;
            pending_swap_r <= 1'b0;
            display_bank_r <= 1'b0;
            frame_done_r   <= 1'b0;
            overflow_r     <= 1'b0;
        end else begin
            x_word_r       <= x_word_n;
            line_base_r    <= line_base_n;
            write_bank_r   <= write_bank_n;
            pending_swap_r <= pending_swap_n;
            display_bank_r <= swap_ready_s ? ~write_bank_r : display_bank_r;
            frame_done_r   <= swap_ready_s;
            overflow_r     <= overflow_r | drop_s;
        end
    end

    // Memory-side view of the FIFO head; idle bus is driven to zero.
    always_comb begin
        mem_req = ~empty_s;
        if (empty_s) begin
            mem_addr = ADDR_W'(0);
            mem_data = DATA_W'(0);
        end else begin
            mem_addr = {head_s.bank, head_s.offset};
            mem_data = head_s.data;
        end
    end

    assign display_bank = display_bank_r;
    assign frame_done   = frame_done_r;
    assign overflow     = overflow_r;

`ifdef NTSC_WRITER_DROP_CNT_EN
    logic [15:0] drop_count_r;

    // Saturating count of dropped words, cleared only by reset.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            drop_count_r <= 16'h0000;
        end else if (drop_s && (drop_count_r != 16'hFFFF)) begin
            drop_count_r <= drop_count_r + 16'h0001;
        end else begin
            drop_count_r <= drop_count_r;
        end
    end

    assign drop_count = drop_count_r;
`endif

endmodule
